pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the RV32IM front end. It drives the PC register's enable and next-PC select, and the stage-register enable/flush controls for IF/ID, ID/EX and EX/MEM.
- Resolves three conditions:
  - taken-branch/jump redirect from EX;
  - load-use stall between ID and EX;
  - multi-cycle stall for the iterative divider in EX.
- Also keeps a free-running stall-cycle performance counter.

Parameters:
DIV_CYCLES, 34, total cycles the divider occupies EX (must be >= 2)
CNT_W, 6, width of the divider cycle counter (must hold DIV_CYCLES-1)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
id_rs1  input  5  rs1 index of instruction in ID
id_rs2  input  5  rs2 index of instruction in ID
id_rs1_used  input  1  ID instruction reads rs1
id_rs2_used  input  1  ID instruction reads rs2
ex_mem_read  input  1  EX instruction is a load
ex_rd  input  5  destination index of EX instruction
ex_is_div  input  1  EX instruction is DIV/DIVU/REM/REMU
ex_branch_taken  input  1  EX resolved a taken branch or jump
ex_branch_target  input  32  redirect address from EX
pc_enable  output  1  PC register enable (0 = hold)
pc_sel  output  1  1 = PC loads pc_target, 0 = PC+4
pc_target  output  32  redirect address to PC mux
if_id_enable  output  1  IF/ID register enable
if_id_flush  output  1  IF/ID loads NOP
id_ex_enable  output  1  ID/EX register enable
id_ex_flush  output  1  ID/EX loads NOP
ex_mem_flush  output  1  EX/MEM loads NOP
div_start  output  1  one-cycle start pulse to divider
perf_stall_cycles  output  32  count of cycles with pc_enable=0

Behaviour:
- The interface is one clock domain, clk. reset is asynchronous and active-high.

Reset:
- While reset is high: state=RUN, div counter=0, perf_stall_cycles=0.
- All control outputs are forced to the reset-idle values: pc_enable=0, if_id_enable=0, id_ex_enable=0, pc_sel=0, all flushes=0, div_start=0, pc_target=0.
- Reset asserted mid-DIV_BUSY aborts the stall immediately. The divider shares the same reset.

Outputs and registered state:
- Outputs are combinational from the registered state plus the current inputs.
- State and counters update on the rising edge of clk.

Defaults (outside reset):
- pc_enable=1, if_id_enable=1, id_ex_enable=1, pc_sel=0, flushes=0, div_start=0.
- pc_target = ex_branch_target at all times.

State RUN, priority order:
1. ex_branch_taken:
   - pc_sel=1, if_id_flush=1, id_ex_flush=1.
   - Enables stay 1.
   - Load-use and div conditions are ignored this cycle; the younger instructions are squashed.
   - Stay in RUN.
2. ex_is_div:
   - div_start=1, pc_enable=0, if_id_enable=0, id_ex_enable=0, ex_mem_flush=1.
   - Load counter with DIV_CYCLES-1; next state DIV_BUSY.
3. Load-use hazard, defined as ex_mem_read && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)):
   - pc_enable=0, if_id_enable=0, id_ex_flush=1 for exactly this cycle.
   - Stay in RUN.
   - A second stall never follows, because the load has moved to MEM.
4. Otherwise: defaults.

State DIV_BUSY:
- counter != 0: pc_enable=0, if_id_enable=0, id_ex_enable=0, ex_mem_flush=1. Decrement counter.
- counter == 0 (release cycle): defaults; next state RUN.
- ex_is_div, ex_branch_taken and load-use inputs are ignored for the whole state, including the release cycle. This prevents re-triggering on the same div.
- Total frontend stall per divide = DIV_CYCLES cycles:
  - 1 start cycle;
  - DIV_CYCLES-1 busy cycles;
  - release cycle not stalled.
- Back-to-back divides: the second div reaches EX in the cycle after release and starts a fresh sequence.

perf_stall_cycles:
- Increments by 1 on each rising edge where pc_enable==0 and reset is low.
- Wraps modulo 2^32.

Test Plan:
- Reset: assert reset asynchronously mid-cycle, including mid-DIV_BUSY -> all enables 0, state RUN, counter 0, perf 0 without waiting for a clock edge. Release -> pc_enable=1 on the first cycle.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> exactly 1 cycle of pc_enable=0, if_id_enable=0, id_ex_flush=1. Repeat with ex_rd=0, or with id_rs2_used=0 -> no stall.
- Branch: ex_branch_taken=1, target 0x0000_0100 -> pc_sel=1, pc_target=0x100, if_id_flush=id_ex_flush=1 for 1 cycle. With a simultaneous load-use hazard -> no stall asserted.
- Divide, DIV_CYCLES=4: ex_is_div held high -> div_start pulses once; pc_enable low exactly 4 cycles, with ex_mem_flush high in those 4 cycles; release on the 5th cycle; perf_stall_cycles=4.
- Back-to-back divides with DIV_CYCLES=4 -> two div_start pulses 5 cycles apart, 8 stall cycles total. A branch_taken asserted during DIV_BUSY -> ignored, pc_sel stays 0.
- Perf wrap: force 500 load-use stalls -> perf_stall_cycles=500. Preload via a long run or use a test hook to show wrap from 0xFFFF_FFFF to 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : front-end sequencer for the RV32IM pipeline (PC enable/select, IF/ID, ID/EX, EX/MEM controls).
// Latency : control outputs are combinational from registered state + current inputs; state updates on clk rise.
// Backpressure: stalls the front end for one cycle on load-use and for DIV_CYCLES cycles per divide.
//
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   id_rs1/id_rs2, *_used          - source registers read by the instruction in ID
//   ex_mem_read, ex_rd             - EX holds a load writing ex_rd
//   ex_is_div                      - EX holds DIV/DIVU/REM/REMU
//   ex_branch_taken/_target        - EX redirect request and address
//   pc_enable, pc_sel, pc_target   - PC register enable, mux select, redirect address
//   if_id_*, id_ex_*, ex_mem_flush - stage register enables / NOP injection
//   div_start                      - one-cycle divider start pulse
//   perf_stall_cycles              - free-running count of cycles with pc_enable low
module pipeline_hazard_ctrl #(
  parameter int DIV_CYCLES = 34,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_div,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  output logic        pc_enable,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic        if_id_enable,
  output logic        if_id_flush,
  output logic        id_ex_enable,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        div_start,
  output logic [31:0] perf_stall_cycles
);

  typedef enum logic {
    RUN      = 1'b0,
    DIV_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] div_cnt, div_cnt_nxt;
  logic [31:0]      perf_cnt;
  logic             load_use;

  // A load writing x0 never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  assign perf_stall_cycles = perf_cnt;

  always_comb begin
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    id_ex_enable = 1'b1;
    pc_sel       = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    div_start    = 1'b0;
    pc_target    = ex_branch_target;
    state_nxt    = state;
    div_cnt_nxt  = div_cnt;

    if (reset) begin
      // Outputs go idle immediately, without waiting for a clock edge.
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      id_ex_enable = 1'b0;
      pc_target    = 32'd0;
      state_nxt    = RUN;
      div_cnt_nxt  = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_branch_taken) begin
            // Redirect squashes the younger instructions, so any hazard they carry is moot.
            pc_sel      = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ex_is_div) begin
            div_start    = 1'b1;
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_enable = 1'b0;
            ex_mem_flush = 1'b1;
            div_cnt_nxt  = DIV_LOAD;
            state_nxt    = DIV_BUSY;
          end else if (load_use) begin
            // One bubble is enough: next cycle the load is in MEM and forwarding covers it.
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
          end
        end
        DIV_BUSY: begin
          // EX inputs are ignored here, including the release cycle, so the
          // divide still sitting in EX cannot re-trigger itself.
          if (div_cnt != '0) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_enable = 1'b0;
            ex_mem_flush = 1'b1;
            div_cnt_nxt  = div_cnt - CNT_W'(1);
          end else begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      div_cnt  <= '0;
      perf_cnt <= 32'd0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      if (!pc_enable) begin
        perf_cnt <= perf_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose : directed bench for pipeline_hazard_ctrl with a cycle-level reference model.
// Latency : model outputs are evaluated each cycle from the current inputs and the divide progress.
// Backpressure: n/a (bench drives all inputs directly).
module tb_pipeline_hazard_ctrl;

  localparam int DC = 4;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_mem_read, ex_is_div, ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        pc_enable, pc_sel, if_id_enable, if_id_flush;
  logic        id_ex_enable, id_ex_flush, ex_mem_flush, div_start;
  logic [31:0] pc_target, perf_stall_cycles;

  pipeline_hazard_ctrl #(.DIV_CYCLES(DC), .CNT_W(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_rs1_used      (id_rs1_used),
    .id_rs2_used      (id_rs2_used),
    .ex_mem_read      (ex_mem_read),
    .ex_rd            (ex_rd),
    .ex_is_div        (ex_is_div),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .pc_enable        (pc_enable),
    .pc_sel           (pc_sel),
    .pc_target        (pc_target),
    .if_id_enable     (if_id_enable),
    .if_id_flush      (if_id_flush),
    .id_ex_enable     (id_ex_enable),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_flush     (ex_mem_flush),
    .div_start        (div_start),
    .perf_stall_cycles(perf_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: divide progress is the number of cycles since div_start
  // (1..DC-1 stalled, DC = release); perf is a plain count of stalled cycles.
  bit          div_active = 1'b0;
  int          div_age    = 0;
  int unsigned perf_m     = 0;

  function automatic logic [39:0] model_out();
    logic pe, ps, ie, iflush, ee, eflush, mflush, ds;
    bit   hazard;
    pe = 1; ps = 0; ie = 1; iflush = 0; ee = 1; eflush = 0; mflush = 0; ds = 0;
    hazard = ex_mem_read && (ex_rd != 0) &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    if (reset) begin
      return 40'd0;
    end
    if (div_active) begin
      if (div_age < DC) begin
        pe = 0; ie = 0; ee = 0; mflush = 1;
      end
    end else if (ex_branch_taken) begin
      ps = 1; iflush = 1; eflush = 1;
    end else if (ex_is_div) begin
      ds = 1; pe = 0; ie = 0; ee = 0; mflush = 1;
    end else if (hazard) begin
      pe = 0; ie = 0; eflush = 1;
    end
    return {pe, ps, ie, iflush, ee, eflush, mflush, ds, ex_branch_target};
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [39:0] e;
    if (reset) begin
      div_active = 1'b0;
      div_age    = 0;
      perf_m     = 0;
    end else begin
      e = model_out();
      if (!e[39]) perf_m++;
      if (div_active) begin
        if (div_age == DC) div_active = 1'b0;
        else div_age++;
      end else if (!ex_branch_taken && ex_is_div) begin
        div_active = 1'b1;
        div_age    = 1;
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("outputs", {24'd0, pc_enable, pc_sel, if_id_enable, if_id_flush, id_ex_enable,
                      id_ex_flush, ex_mem_flush, div_start, pc_target}, {24'd0, model_out()});
      chk("perf", {32'd0, perf_stall_cycles}, {32'd0, perf_m});
    end
  end

  // Window monitor for the divide scenarios.
  bit mon_en = 1'b0;
  int mon_cycle;
  int n_start, n_low, n_mflush, n_psel;
  int start_at[2];
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (div_start) begin
        if (n_start < 2) start_at[n_start] = mon_cycle;
        n_start++;
      end
      if (!pc_enable) n_low++;
      if (!pc_enable && ex_mem_flush) n_mflush++;
      if (pc_sel) n_psel++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_mem_read = 0; ex_rd = 0; ex_is_div = 0; ex_branch_taken = 0;
  endtask

  task automatic load_use(input logic [4:0] rd);
    ex_mem_read = 1; ex_rd = rd; id_rs2 = rd; id_rs2_used = 1;
  endtask

  task automatic mon_clear();
    n_start = 0; n_low = 0; n_mflush = 0; n_psel = 0;
    start_at[0] = -1; start_at[1] = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    ex_branch_target = 32'hDEAD_BEEF;
    mon_clear();
    #3;
    chk("rst_pc_enable", {63'd0, pc_enable}, 64'd0);
    chk("rst_id_ex_enable", {63'd0, id_ex_enable}, 64'd0);
    chk("rst_pc_target", {32'd0, pc_target}, 64'd0);
    chk("rst_perf", {32'd0, perf_stall_cycles}, 64'd0);
    cmp_en = 1'b1;
    #9;  // t=12, between edges
    reset = 1'b0;
    #1;
    chk("release_pc_enable", {63'd0, pc_enable}, 64'd1);
    chk("release_pc_target", {32'd0, pc_target}, 64'hDEAD_BEEF);

    // Load-use on rs2
    step(); load_use(5'd5); #1;
    chk("lu_pc_enable", {63'd0, pc_enable}, 64'd0);
    chk("lu_if_id_enable", {63'd0, if_id_enable}, 64'd0);
    chk("lu_id_ex_flush", {63'd0, id_ex_flush}, 64'd1);
    step(); clear_inputs(); #1;
    chk("lu_one_cycle_perf", {32'd0, perf_stall_cycles}, 64'd1);
    chk("lu_released", {63'd0, pc_enable}, 64'd1);
    // x0 destination: no hazard
    step(); load_use(5'd0); #1;
    chk("lu_rd0", {63'd0, pc_enable}, 64'd1);
    // rs2 not read: no hazard
    step(); load_use(5'd5); id_rs2_used = 0; #1;
    chk("lu_unused", {63'd0, pc_enable}, 64'd1);
    // rs1 dependency
    step(); clear_inputs(); ex_mem_read = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1; #1;
    chk("lu_rs1", {63'd0, pc_enable}, 64'd0);
    step(); clear_inputs();

    // Branch redirect, alone then with a concurrent load-use
    step(); ex_branch_taken = 1; ex_branch_target = 32'h0000_0100; #1;
    chk("br_pc_sel", {63'd0, pc_sel}, 64'd1);
    chk("br_pc_target", {32'd0, pc_target}, 64'h100);
    chk("br_flushes", {62'd0, if_id_flush, id_ex_flush}, 64'd3);
    step(); load_use(5'd5); #1;
    chk("br_lu_no_stall", {62'd0, pc_enable, if_id_enable}, 64'd3);
    step(); clear_inputs(); #1;
    chk("perf_before_div", {32'd0, perf_stall_cycles}, 64'd2);

    // Single divide, ex_is_div held through release
    mon_clear();
    for (int c = 0; c <= 5; c++) begin
      step();
      ex_is_div = (c < 5);
      mon_cycle = c;
      mon_en = 1'b1;
      if (c == 4) begin
        #1;
        chk("div_release_pc_enable", {63'd0, pc_enable}, 64'd1);
        chk("div_release_no_start", {63'd0, div_start}, 64'd0);
      end
    end
    step(); mon_en = 1'b0;
    chk("div_start_count", 64'(n_start), 64'd1);
    chk("div_stall_cycles", 64'(n_low), 64'd4);
    chk("div_mem_flush_cycles", 64'(n_mflush), 64'd4);
    chk("div_perf", {32'd0, perf_stall_cycles}, 64'd6);

    // Back-to-back divides, branch asserted during the first busy window
    mon_clear();
    for (int c = 0; c <= 10; c++) begin
      step();
      ex_is_div = (c < 10);
      ex_branch_taken = (c >= 1 && c <= 4);
      mon_cycle = c;
      mon_en = 1'b1;
    end
    step(); mon_en = 1'b0; clear_inputs();
    chk("b2b_start_count", 64'(n_start), 64'd2);
    chk("b2b_start_spacing", 64'(start_at[1] - start_at[0]), 64'd5);
    chk("b2b_stall_cycles", 64'(n_low), 64'd8);
    chk("b2b_branch_ignored", 64'(n_psel), 64'd0);
    chk("b2b_perf", {32'd0, perf_stall_cycles}, 64'd14);

    // Asynchronous reset in the middle of a divide
    step(); ex_is_div = 1;
    step(); step();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_div_rst_enables", {61'd0, pc_enable, if_id_enable, id_ex_enable}, 64'd0);
    chk("mid_div_rst_mflush", {63'd0, ex_mem_flush}, 64'd0);
    chk("mid_div_rst_perf", {32'd0, perf_stall_cycles}, 64'd0);
    clear_inputs();
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_div_release_run", {63'd0, pc_enable}, 64'd1);

    // 500 isolated load-use stalls
    for (int i = 0; i < 1000; i++) begin
      step();
      if (i % 2 == 0) load_use(5'd9);
      else clear_inputs();
    end
    step(); clear_inputs(); #1;
    chk("perf_500", {32'd0, perf_stall_cycles}, 64'd500);

    step(); step();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
